// File: rtl/fir_mac_serial_if.sv
// Sample/result handshake plus coefficient write port for fir_mac_serial.
// The master side drives samples and coefficients; the slave side is the filter.
interface fir_mac_serial_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 16,
  parameter int ADDR_W = 2
);
  logic                     clear;
  logic                     coef_we;
  logic [ADDR_W-1:0]        coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;

  modport master (
    output clear, coef_we, coef_addr, coef_data, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  clear, coef_we, coef_addr, coef_data, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fir_mac_serial.sv
// Time-multiplexed FIR: one shared multiplier walks the TAPS-deep delay line,
// one output per accepted sample, with arithmetic shift and output saturation.
module fir_mac_serial #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 4,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0
) (
  input logic            clk,
  input logic            rst,
  fir_mac_serial_if.slave bus
);
  localparam int KW     = $clog2(TAPS);
  localparam int PROD_W = COEF_W + DATA_W;
  localparam int ACC_W  = DATA_W + COEF_W + KW;
  localparam int SW     = (ACC_W > OUT_W) ? ACC_W : OUT_W;

  localparam logic [KW-1:0]            LAST     = KW'(TAPS - 1);
  localparam logic [KW:0]              TAPS_LIM = (KW + 1)'(TAPS);
  localparam logic signed [OUT_W-1:0]  OUT_MAX  = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic signed [OUT_W-1:0]  OUT_MIN  = {1'b1, {(OUT_W - 1){1'b0}}};
  localparam logic signed [SW-1:0]     SAT_HI   = SW'(OUT_MAX);
  localparam logic signed [SW-1:0]     SAT_LO   = SW'(OUT_MIN);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                   state;
  logic signed [DATA_W-1:0] x [TAPS];
  logic signed [COEF_W-1:0] h [TAPS];
  logic [KW-1:0]            k;
  logic signed [ACC_W-1:0]  acc;
  logic                     in_ready_r;
  logic                     out_valid_r;
  logic signed [OUT_W-1:0]  out_data_r;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [SW-1:0]     sum_ext;
  logic signed [SW-1:0]     shifted;
  logic signed [OUT_W-1:0]  sat_val;

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;

  // The single shared multiplier; the product feeds the accumulator unregistered.
  assign prod     = PROD_W'(h[k]) * PROD_W'(x[k]);
  assign acc_next = acc + ACC_W'(prod);

  always_comb begin
    sum_ext = SW'(acc_next);
    shifted = sum_ext >>> SHIFT;
    sat_val = shifted[OUT_W-1:0];
    if (shifted > SAT_HI) begin
      sat_val = OUT_MAX;
    end else if (shifted < SAT_LO) begin
      sat_val = OUT_MIN;
    end
  end

  // Coefficient writes and clear are honoured only while idle, so an in-flight
  // result always sees a frozen coefficient bank and delay line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      acc         <= '0;
      k           <= '0;
      for (int i = 0; i < TAPS; i++) begin
        x[i] <= '0;
        h[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.coef_we && ({1'b0, bus.coef_addr} < TAPS_LIM)) begin
            h[bus.coef_addr] <= bus.coef_data;
          end
          if (bus.clear) begin
            for (int i = 0; i < TAPS; i++) begin
              x[i] <= '0;
            end
          end else if (bus.in_valid) begin
            for (int i = TAPS - 1; i > 0; i--) begin
              x[i] <= x[i-1];
            end
            x[0]       <= bus.in_data;
            acc        <= '0;
            k          <= '0;
            in_ready_r <= 1'b0;
            state      <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          k   <= k + 1'b1;
          if (k == LAST) begin
            out_data_r  <= sat_val;
            out_valid_r <= 1'b1;
            state       <= OUT;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fir_mac_serial.sv
// Directed bench for fir_mac_serial: a 4-tap unshifted instance and a 3-tap
// instance with SHIFT=2, checked against hand-computed results.
module tb_fir_mac_serial;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  fir_mac_serial_if #(.DATA_W(8), .COEF_W(8), .OUT_W(16), .ADDR_W(2)) b0 ();
  fir_mac_serial_if #(.DATA_W(8), .COEF_W(8), .OUT_W(16), .ADDR_W(2)) b1 ();

  fir_mac_serial #(.DATA_W(8), .COEF_W(8), .TAPS(4), .OUT_W(16), .SHIFT(0)) u0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  fir_mac_serial #(.DATA_W(8), .COEF_W(8), .TAPS(3), .OUT_W(16), .SHIFT(2)) u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr0(input int a, input int d);
    @(negedge clk);
    b0.coef_we   = 1'b1;
    b0.coef_addr = a[1:0];
    b0.coef_data = d[7:0];
    @(negedge clk);
    b0.coef_we = 1'b0;
  endtask

  task automatic wr1(input int a, input int d);
    @(negedge clk);
    b1.coef_we   = 1'b1;
    b1.coef_addr = a[1:0];
    b1.coef_data = d[7:0];
    @(negedge clk);
    b1.coef_we = 1'b0;
  endtask

  task automatic set0(input int c0, input int c1, input int c2, input int c3);
    wr0(0, c0); wr0(1, c1); wr0(2, c2); wr0(3, c3);
  endtask

  task automatic clr0();
    @(negedge clk);
    b0.clear = 1'b1;
    @(negedge clk);
    b0.clear = 1'b0;
  endtask

  // Offers one sample, then counts negedges until out_valid (99 on timeout).
  task automatic send0(input int d, output int y, output int lat);
    @(negedge clk);
    b0.in_valid = 1'b1;
    b0.in_data  = d[7:0];
    @(negedge clk);
    b0.in_valid = 1'b0;
    lat = 0;
    while (b0.out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) lat = 99;
    y = int'(b0.out_data);
  endtask

  task automatic send1(input int d, output int y, output int lat);
    @(negedge clk);
    b1.in_valid = 1'b1;
    b1.in_data  = d[7:0];
    @(negedge clk);
    b1.in_valid = 1'b0;
    lat = 0;
    while (b1.out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) lat = 99;
    y = int'(b1.out_data);
  endtask

  task automatic test_reset();
    vectors++;
    if (b0.in_ready !== 1'b1 || b0.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_hs got ready=%b valid=%b expected ready=1 valid=0", b0.in_ready, b0.out_valid);
    end
    vectors++;
    if (b0.out_data !== 16'sd0) begin
      miscompares++;
      $display("[TB] FAIL reset_data got %0d expected 0", b0.out_data);
    end
  endtask

  task automatic test_impulse();
    int exp_y [5] = '{1, 2, 3, 4, 0};
    int smp [5] = '{1, 0, 0, 0, 0};
    int y, lat;
    set0(1, 2, 3, 4);
    b0.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send0(smp[i], y, lat);
      vectors++;
      if (y !== exp_y[i] || lat !== 4) begin
        miscompares++;
        $display("[TB] FAIL impulse[%0d] got y=%0d lat=%0d expected y=%0d lat=4", i, y, lat, exp_y[i]);
      end
    end
    @(negedge clk);
    vectors++;
    if (b0.out_valid !== 1'b0 || b0.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL pulse_end got valid=%b ready=%b expected valid=0 ready=1", b0.out_valid, b0.in_ready);
    end
  endtask

  task automatic test_saturation();
    int y, lat;
    set0(-128, -128, -128, -128);
    send0(-128, y, lat);
    vectors++;
    if (y !== 16384) begin
      miscompares++;
      $display("[TB] FAIL sat_first got %0d expected 16384", y);
    end
    for (int i = 0; i < 3; i++) send0(-128, y, lat);
    vectors++;
    if (y !== 32767) begin
      miscompares++;
      $display("[TB] FAIL sat_pos got %0d expected 32767", y);
    end
    set0(127, 127, 127, 127);
    for (int i = 0; i < 4; i++) send0(-128, y, lat);
    vectors++;
    if (y !== -32768) begin
      miscompares++;
      $display("[TB] FAIL sat_neg got %0d expected -32768", y);
    end
  endtask

  task automatic test_backpressure();
    int y, lat;
    set0(1, 2, 3, 4);
    clr0();
    b0.out_ready = 1'b0;
    send0(5, y, lat);
    vectors++;
    if (y !== 5 || lat !== 4) begin
      miscompares++;
      $display("[TB] FAIL bp_first got y=%0d lat=%0d expected y=5 lat=4", y, lat);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if (b0.out_data !== 16'sd5 || b0.in_ready !== 1'b0 || b0.out_valid !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL bp_hold[%0d] got data=%0d ready=%b valid=%b expected 5/0/1", i, b0.out_data, b0.in_ready, b0.out_valid);
      end
      b0.in_valid = (i % 2 == 0);
      b0.in_data  = 8'sd99;
    end
    @(negedge clk);
    b0.in_valid  = 1'b0;
    b0.out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (b0.out_valid !== 1'b0 || b0.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bp_release got valid=%b ready=%b expected valid=0 ready=1", b0.out_valid, b0.in_ready);
    end
    send0(0, y, lat);
    vectors++;
    if (y !== 10) begin
      miscompares++;
      $display("[TB] FAIL bp_history got %0d expected 10", y);
    end
  endtask

  task automatic test_coef_write();
    int y, lat, cnt;
    set0(1, 2, 3, 4);
    clr0();
    @(negedge clk);
    b0.in_valid = 1'b1;
    b0.in_data  = 8'sd1;
    @(negedge clk);
    b0.in_valid  = 1'b0;
    b0.coef_we   = 1'b1;
    b0.coef_addr = 2'd0;
    b0.coef_data = 8'sd50;
    @(negedge clk);
    b0.coef_we = 1'b0;
    cnt = 0;
    while (b0.out_valid !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    vectors++;
    if (int'(b0.out_data) !== 1 || cnt >= 20) begin
      miscompares++;
      $display("[TB] FAIL coef_mac_inflight got %0d expected 1", b0.out_data);
    end
    send0(3, y, lat);
    vectors++;
    if (y !== 5) begin
      miscompares++;
      $display("[TB] FAIL coef_mac_dropped got %0d expected 5", y);
    end
    @(negedge clk);
    b0.coef_we   = 1'b1;
    b0.coef_addr = 2'd0;
    b0.coef_data = 8'sd9;
    b0.in_valid  = 1'b1;
    b0.in_data   = 8'sd2;
    @(negedge clk);
    b0.coef_we  = 1'b0;
    b0.in_valid = 1'b0;
    cnt = 0;
    while (b0.out_valid !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    vectors++;
    if (int'(b0.out_data) !== 27 || cnt >= 20) begin
      miscompares++;
      $display("[TB] FAIL coef_same_cycle got %0d expected 27", b0.out_data);
    end
  endtask

  task automatic test_shift();
    int y, lat;
    b1.out_ready = 1'b1;
    wr1(0, 4);
    send1(-3, y, lat);
    vectors++;
    if (y !== -3 || lat !== 3) begin
      miscompares++;
      $display("[TB] FAIL shift_neg got y=%0d lat=%0d expected y=-3 lat=3", y, lat);
    end
    wr1(0, 1);
    send1(5, y, lat);
    vectors++;
    if (y !== 1) begin
      miscompares++;
      $display("[TB] FAIL shift_pos got %0d expected 1", y);
    end
    wr1(3, 100);
    send1(8, y, lat);
    vectors++;
    if (y !== 2) begin
      miscompares++;
      $display("[TB] FAIL addr_oob got %0d expected 2", y);
    end
  endtask

  task automatic test_reset_abort();
    int y, lat;
    set0(1, 2, 3, 4);
    @(negedge clk);
    b0.in_valid = 1'b1;
    b0.in_data  = 8'sd1;
    @(negedge clk);
    b0.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (b0.in_ready !== 1'b1 || b0.out_valid !== 1'b0 || b0.out_data !== 16'sd0) begin
      miscompares++;
      $display("[TB] FAIL rst_mac got ready=%b valid=%b data=%0d expected 1/0/0", b0.in_ready, b0.out_valid, b0.out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    set0(1, 2, 3, 4);
    send0(1, y, lat);
    vectors++;
    if (y !== 1 || lat !== 4) begin
      miscompares++;
      $display("[TB] FAIL rst_impulse got y=%0d lat=%0d expected y=1 lat=4", y, lat);
    end
    @(negedge clk);
    b0.out_ready = 1'b0;
    send0(0, y, lat);
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (b0.out_valid !== 1'b0 || b0.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rst_out got valid=%b ready=%b expected valid=0 ready=1", b0.out_valid, b0.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    b0.out_ready = 1'b1;
  endtask

  task automatic test_clear();
    int y, lat;
    set0(1, 2, 3, 4);
    send0(7, y, lat);
    send0(9, y, lat);
    @(negedge clk);
    b0.clear    = 1'b1;
    b0.in_valid = 1'b1;
    b0.in_data  = 8'sd55;
    @(negedge clk);
    b0.clear    = 1'b0;
    b0.in_valid = 1'b0;
    vectors++;
    if (b0.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL clear_drop got ready=%b expected 1", b0.in_ready);
    end
    send0(2, y, lat);
    vectors++;
    if (y !== 2) begin
      miscompares++;
      $display("[TB] FAIL clear_history got %0d expected 2", y);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    b0.clear = 1'b0; b0.coef_we = 1'b0; b0.coef_addr = '0; b0.coef_data = '0;
    b0.in_valid = 1'b0; b0.in_data = '0; b0.out_ready = 1'b1;
    b1.clear = 1'b0; b1.coef_we = 1'b0; b1.coef_addr = '0; b1.coef_data = '0;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_impulse();
    test_saturation();
    test_backpressure();
    test_coef_write();
    test_shift();
    test_reset_abort();
    test_clear();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
